// File: rtl/br_pred_unit.sv
// Execute-stage branch resolution with a direct-mapped 2-bit-counter branch target table,
// registered mispredict redirect, and branch/mispredict statistics.
module br_pred_unit #(
  parameter int         XLEN     = 32,
  parameter int         IDX_BITS = 4,
  parameter int         CTR_W    = 32,
  parameter logic [2:0] BR_BEQ   = 3'd0,
  parameter logic [2:0] BR_BNE   = 3'd1,
  parameter logic [2:0] BR_JAL   = 3'd2,
  parameter logic [2:0] BR_JALR  = 3'd3,
  parameter logic [2:0] BR_BLT   = 3'd4,
  parameter logic [2:0] BR_BGE   = 3'd5,
  parameter logic [2:0] BR_BLTU  = 3'd6,
  parameter logic [2:0] BR_BGEU  = 3'd7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic             ex_br,
  input  logic [2:0]       ex_op,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic [XLEN-1:0]  link_pc,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CTR_W-1:0] stat_branches,
  output logic [CTR_W-1:0] stat_mispredicts
);

  localparam int              ENTRIES = 1 << IDX_BITS;
  localparam int              TAG_W   = XLEN - IDX_BITS - 2;
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic             r_redirect;
  logic [XLEN-1:0]  r_redirect_pc;
  logic [CTR_W-1:0] r_branches;
  logic [CTR_W-1:0] r_mispredicts;

  // Fetch-side lookup; reads pre-update contents when EX writes the same index
  logic [IDX_BITS-1:0] w_if_idx;
  logic [TAG_W-1:0]    w_if_tag;
  logic                w_if_hit;

  assign w_if_idx    = if_pc[IDX_BITS+1:2];
  assign w_if_tag    = if_pc[XLEN-1:IDX_BITS+2];
  assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
  assign pred_target = pred_taken ? r_target[w_if_idx] : (if_pc + FOUR);

  // Execute-side resolution
  logic                w_eq, w_lt, w_ltu, w_taken, w_is_jump;
  logic [XLEN-1:0]     w_jalr_sum, w_target;
  logic                w_live, w_mispredict;
  logic [IDX_BITS-1:0] w_ex_idx;
  logic [TAG_W-1:0]    w_ex_tag;
  logic                w_ex_hit;

  assign w_eq       = (ex_rs1 == ex_rs2);
  assign w_lt       = ($signed(ex_rs1) < $signed(ex_rs2));
  assign w_ltu      = (ex_rs1 < ex_rs2);
  assign w_is_jump  = (ex_op == BR_JAL) || (ex_op == BR_JALR);
  assign w_jalr_sum = ex_rs1 + ex_imm;
  assign w_target   = (ex_op == BR_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
  assign link_pc    = ex_pc + FOUR;

  always_comb begin
    w_taken = 1'b0;
    case (ex_op)
      BR_BEQ:  w_taken = w_eq;
      BR_BNE:  w_taken = !w_eq;
      BR_BLT:  w_taken = w_lt;
      BR_BGE:  w_taken = !w_lt;
      BR_BLTU: w_taken = w_ltu;
      BR_BGEU: w_taken = !w_ltu;
      BR_JAL:  w_taken = 1'b1;
      BR_JALR: w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  // While a redirect is out, the EX slot holds a wrong-path instruction
  assign w_live       = ex_valid && ex_br && !r_redirect;
  assign w_mispredict = w_live && ((w_taken != ex_pred_taken) ||
                                   (w_taken && (w_target != ex_pred_target)));

  assign w_ex_idx = ex_pc[IDX_BITS+1:2];
  assign w_ex_tag = ex_pc[XLEN-1:IDX_BITS+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'd0;
      end
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_branches    <= '0;
      r_mispredicts <= '0;
    end else begin
      r_redirect <= w_mispredict;
      if (w_mispredict) begin
        r_redirect_pc <= w_taken ? w_target : link_pc;
        r_mispredicts <= r_mispredicts + 1'b1;
      end
      if (w_live) begin
        r_branches <= r_branches + 1'b1;
        if (w_ex_hit) begin
          if (w_taken) begin
            r_ctr[w_ex_idx]    <= (w_is_jump || r_ctr[w_ex_idx] == 2'd3) ? 2'd3
                                  : r_ctr[w_ex_idx] + 2'd1;
            r_target[w_ex_idx] <= w_target;
          end else begin
            r_ctr[w_ex_idx] <= (r_ctr[w_ex_idx] == 2'd0) ? 2'd0 : r_ctr[w_ex_idx] - 2'd1;
          end
        end else if (w_taken) begin
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= w_ex_tag;
          r_target[w_ex_idx] <= w_target;
          r_ctr[w_ex_idx]    <= w_is_jump ? 2'd3 : 2'd2;
        end
      end
    end
  end

  assign redirect         = r_redirect;
  assign redirect_pc      = r_redirect_pc;
  assign stat_branches    = r_branches;
  assign stat_mispredicts = r_mispredicts;

endmodule

// File: tb/tb_br_pred_unit.sv
// Scenario bench for br_pred_unit: expected redirect/redirect_pc pairs are queued when each
// EX cycle is driven and popped one edge later; lookups and stats are checked inline.
module tb_br_pred_unit;

  localparam logic [2:0] BEQ = 3'd0, BNE = 3'd1, JAL = 3'd2, JALR = 3'd3;
  localparam logic [2:0] BLT = 3'd4, BGE = 3'd5, BLTU = 3'd6, BGEU = 3'd7;

  logic        clk, rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_br;
  logic [2:0]  ex_op;
  logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] link_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches, stat_mispredicts;

  logic [32:0] exp_q[$];
  logic [32:0] exp_v;
  int n_chk  = 0;
  int n_pass = 0;

  br_pred_unit dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_br(ex_br), .ex_op(ex_op), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .link_pc(link_pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drivers
  task automatic drive_ex(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic pt,
                          input logic [31:0] ptgt, input logic exp_r, input logic [31:0] exp_pc);
    ex_valid = 1'b1; ex_br = 1'b1; ex_op = op; ex_pc = pc; ex_imm = imm;
    ex_rs1 = rs1; ex_rs2 = rs2; ex_pred_taken = pt; ex_pred_target = ptgt;
    exp_q.push_back({exp_r, exp_pc});
  endtask

  task automatic drive_idle(input logic exp_r, input logic [31:0] exp_pc);
    ex_valid = 1'b0; ex_br = 1'b0;
    exp_q.push_back({exp_r, exp_pc});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ex_valid = 1'b0; ex_br = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if_pc = 32'h100; ex_pc = 32'h100;
    #1;
    n_chk++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0) $display("FAIL reset_redirect: got %b/%h expected 0/0", redirect, redirect_pc);
    else n_pass++;
    n_chk++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
    else n_pass++;
    n_chk++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) $display("FAIL reset_lookup: got %b/%h expected 0/104", pred_taken, pred_target);
    else n_pass++;
    n_chk++;
    if (link_pc !== 32'h104) $display("FAIL link_pc: got %h expected 104", link_pc);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_cold_beq();
    drive_ex(BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0, 1'b1, 32'h120);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL cold_beq_redirect: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    if_pc = 32'h100; #1;
    n_chk++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h120) $display("FAIL cold_beq_lookup: got %b/%h expected 1/120", pred_taken, pred_target);
    else n_pass++;
    drive_idle(1'b0, 32'h120);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL cold_beq_deassert: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    n_chk++;
    if (stat_branches !== 32'd1 || stat_mispredicts !== 32'd1) $display("FAIL cold_beq_stats: got %0d/%0d expected 1/1", stat_branches, stat_mispredicts);
    else n_pass++;
  endtask

  task automatic test_signed_unsigned();
    drive_ex(BLTU, 32'h200, 32'h40, 32'h1, 32'hFFFF_FFFF, 1'b1, 32'h240, 1'b0, 32'h120);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL bltu_taken: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    drive_ex(BLT, 32'h300, 32'h40, 32'h1, 32'hFFFF_FFFF, 1'b1, 32'h340, 1'b1, 32'h304);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL blt_not_taken: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    drive_idle(1'b0, 32'h304);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL blt_deassert: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    if_pc = 32'h200; #1;
    n_chk++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h240) $display("FAIL bltu_alloc_lookup: got %b/%h expected 1/240", pred_taken, pred_target);
    else n_pass++;
    n_chk++;
    if (stat_branches !== 32'd3 || stat_mispredicts !== 32'd2) $display("FAIL cmp_stats: got %0d/%0d expected 3/2", stat_branches, stat_mispredicts);
    else n_pass++;
  endtask

  task automatic test_jalr();
    drive_ex(JALR, 32'h404, 32'h10, 32'h203, 32'h0, 1'b1, 32'h212, 1'b0, 32'h304);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL jalr_correct: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    n_chk++;
    if (stat_branches !== 32'd4 || stat_mispredicts !== 32'd2) $display("FAIL jalr_stats: got %0d/%0d expected 4/2", stat_branches, stat_mispredicts);
    else n_pass++;
    // A not-taken hit from a forced ctr=3 must still leave the entry predicting taken
    drive_ex(BEQ, 32'h404, 32'h10, 32'd1, 32'd2, 1'b1, 32'h212, 1'b1, 32'h408);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL jalr_entry_nt: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    drive_idle(1'b0, 32'h408);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL jalr_idle: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    if_pc = 32'h404; #1;
    n_chk++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h212) $display("FAIL jalr_ctr3_lookup: got %b/%h expected 1/212", pred_taken, pred_target);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive_ex(BNE, 32'h508, 32'h8, 32'd1, 32'd2, 1'b0, 32'h0, 1'b1, 32'h510);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL b2b_first: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    drive_ex(BEQ, 32'h60C, 32'h100, 32'd7, 32'd7, 1'b0, 32'h0, 1'b0, 32'h510);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL b2b_squashed: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    drive_idle(1'b0, 32'h510);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL b2b_idle: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    n_chk++;
    if (stat_branches !== 32'd6 || stat_mispredicts !== 32'd4) $display("FAIL b2b_stats: got %0d/%0d expected 6/4", stat_branches, stat_mispredicts);
    else n_pass++;
    if_pc = 32'h60C; #1;
    n_chk++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h610) $display("FAIL b2b_no_alloc: got %b/%h expected 0/610", pred_taken, pred_target);
    else n_pass++;
  endtask

  task automatic test_saturation();
    drive_ex(BGE, 32'h710, 32'h30, 32'd5, 32'd3, 1'b0, 32'h0, 1'b1, 32'h740);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL sat_alloc: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    drive_idle(1'b0, 32'h740);
    tick();
    void'(exp_q.pop_front());
    for (int k = 0; k < 4; k++) begin
      drive_ex(BGE, 32'h710, 32'h30, 32'd5, 32'd3, 1'b1, 32'h740, 1'b0, 32'h740);
      tick();
      exp_v = exp_q.pop_front(); n_chk++;
      if ({redirect, redirect_pc} !== exp_v) $display("FAIL sat_taken_%0d: got %h expected %h", k, {redirect, redirect_pc}, exp_v);
      else n_pass++;
    end
    // ctr 3 -> 2: still predicts taken
    drive_ex(BGEU, 32'h710, 32'h30, 32'd3, 32'd5, 1'b1, 32'h740, 1'b1, 32'h714);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL sat_nt1: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    drive_idle(1'b0, 32'h714);
    tick();
    void'(exp_q.pop_front());
    if_pc = 32'h710; #1;
    n_chk++;
    if (pred_taken !== 1'b1) $display("FAIL sat_after_nt1: got %b expected 1", pred_taken);
    else n_pass++;
    // ctr 2 -> 1, with same-cycle lookup of the updating entry
    drive_ex(BGEU, 32'h710, 32'h30, 32'd3, 32'd5, 1'b1, 32'h740, 1'b1, 32'h714);
    #1;
    n_chk++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h740) $display("FAIL same_cycle_lookup: got %b/%h expected 1/740", pred_taken, pred_target);
    else n_pass++;
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL sat_nt2: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    n_chk++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h714) $display("FAIL sat_after_nt2: got %b/%h expected 0/714", pred_taken, pred_target);
    else n_pass++;
    drive_idle(1'b0, 32'h714);
    tick();
    void'(exp_q.pop_front());
    // ctr 1 -> 0, correctly predicted not taken
    drive_ex(BGEU, 32'h710, 32'h30, 32'd3, 32'd5, 1'b0, 32'h0, 1'b0, 32'h714);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL sat_nt3: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    // ctr 0 -> 1 on a taken outcome: prediction must remain not-taken
    drive_ex(BGE, 32'h710, 32'h30, 32'd5, 32'd3, 1'b0, 32'h0, 1'b1, 32'h740);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL sat_floor_taken: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    n_chk++;
    if (pred_taken !== 1'b0) $display("FAIL sat_floor_lookup: got %b expected 0", pred_taken);
    else n_pass++;
    drive_idle(1'b0, 32'h740);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL sat_idle: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    n_chk++;
    if (stat_branches !== 32'd15 || stat_mispredicts !== 32'd8) $display("FAIL sat_stats: got %0d/%0d expected 15/8", stat_branches, stat_mispredicts);
    else n_pass++;
  endtask

  task automatic test_reset_pending();
    drive_ex(BEQ, 32'h800, 32'h4, 32'd9, 32'd9, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL rst_drop_redirect: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
    n_chk++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) $display("FAIL rst_stats: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
    else n_pass++;
    if_pc = 32'h710; #1;
    n_chk++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h714) $display("FAIL rst_lookup_710: got %b/%h expected 0/714", pred_taken, pred_target);
    else n_pass++;
    if_pc = 32'h404; #1;
    n_chk++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h408) $display("FAIL rst_lookup_404: got %b/%h expected 0/408", pred_taken, pred_target);
    else n_pass++;
    rst = 1'b0;
    drive_idle(1'b0, 32'h0);
    tick();
    exp_v = exp_q.pop_front(); n_chk++;
    if ({redirect, redirect_pc} !== exp_v) $display("FAIL rst_after: got %h expected %h", {redirect, redirect_pc}, exp_v);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_br = 1'b0; ex_op = BEQ;
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0; ex_rs2 = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
    test_reset();
    test_cold_beq();
    test_signed_unsigned();
    test_jalr();
    test_back_to_back();
    test_saturation();
    test_reset_pending();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
